// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared phase, opcode and state definitions for the memory access controller
package mem_access_ctrl_pkg;

  localparam int PHASE_H = 4;
  localparam int PH_F    = 0;
  localparam int PH_M    = 3;

  // Opcode patterns over {op1, op2, op3}; masked-out bits are don't-care
  localparam logic [12:0] OP_MASK = 13'b11111111_00_111;
  localparam logic [12:0] ZLD_VAL = 13'b00000011_00_010;
  localparam logic [12:0] ZST_VAL = 13'b00100011_00_010;

  typedef enum logic [2:0] {
    MA_IDLE   = 3'd0,
    MA_WAIT_F = 3'd1,
    MA_WAIT_L = 3'd2,
    MA_WAIT_S = 3'd3,
    MA_DONE   = 3'd4
  } ma_state_e;

  function automatic logic op_match(input logic [7:0] op1, input logic [1:0] op2,
                                    input logic [2:0] op3, input logic [12:0] val);
    return (({op1, op2, op3} & OP_MASK) == val);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - req/ack word-memory bus between the controller and the memory
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// rtl/mem_access_ctrl_timeout_cnt.sv - saturating watchdog counter for outstanding memory accesses
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the wait cycle whose increment would make the count reach TIMEOUT
  assign expire_o = (TIMEOUT != 0) && enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU-side memory initiator: fetch/load/store requests with req/ack and watchdog
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_H:0]   phase_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        ma_i,
  input  logic [7:0]         op1_i,
  input  logic [1:0]         op2_i,
  input  logic [2:0]         op3_i,
  input  logic [31:0]        store_data_i,
  mem_access_ctrl_if.master  bus,
  output logic [31:0]        ir_o,
  output logic [31:0]        mdr_o,
  output logic               stall_o,
  output logic               err_o
);
  ma_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;
  logic              fetch_q, fetch_d;
  logic              waiting;
  logic              expire;
  logic              is_ld;
  logic              is_st;
  logic              unused_bits;

  assign is_ld   = op_match(op1_i, op2_i, op3_i, ZLD_VAL);
  assign is_st   = op_match(op1_i, op2_i, op3_i, ZST_VAL);
  assign waiting = (state_q == MA_WAIT_F) || (state_q == MA_WAIT_L) || (state_q == MA_WAIT_S);
  assign unused_bits = ^{phase_i, pc_i, ma_i};

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == MA_IDLE),
    .enable_i (waiting && !bus.mem_ack),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    stall_d = stall_q;
    err_d   = err_q;
    fetch_d = fetch_q;
    case (state_q)
      MA_IDLE: begin
        if (phase_i[PH_F]) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_i[ADDR_W-1:0];
          stall_d = 1'b1;
          fetch_d = 1'b1;
          state_d = MA_WAIT_F;
        end else if (phase_i[PH_M] && is_ld) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = ma_i[ADDR_W-1:0];
          stall_d = 1'b1;
          fetch_d = 1'b0;
          state_d = MA_WAIT_L;
        end else if (phase_i[PH_M] && is_st) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = ma_i[ADDR_W-1:0];
          wdata_d = store_data_i;
          stall_d = 1'b1;
          fetch_d = 1'b0;
          state_d = MA_WAIT_S;
        end
      end
      MA_WAIT_F, MA_WAIT_L, MA_WAIT_S: begin
        // Ack beats a watchdog expiry landing in the same cycle
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          stall_d = 1'b0;
          if (state_q == MA_WAIT_F) ir_d  = bus.mem_rdata;
          if (state_q == MA_WAIT_L) mdr_d = bus.mem_rdata;
          state_d = MA_DONE;
        end else if (expire) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          stall_d = 1'b0;
          err_d   = 1'b1;
          state_d = MA_DONE;
        end
      end
      MA_DONE: begin
        // Hold here while the triggering phase is still high so it cannot re-issue
        if (fetch_q ? !phase_i[PH_F] : !phase_i[PH_M]) begin
          state_d = MA_IDLE;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MA_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      fetch_q <= fetch_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign ir_o          = ir_q;
  assign mdr_o         = mdr_q;
  assign stall_o       = stall_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PHASE_H:0] phase = '0;
  logic [31:0]      pc = '0, ma = '0, store_data = '0;
  logic [7:0]       op1 = '0;
  logic [1:0]       op2 = '0;
  logic [2:0]       op3 = '0;
  logic [31:0]      ir, mdr;
  logic             stall, err;

  logic             resp_en = 1'b0;
  logic             man_ack = 1'b0;
  int               ack_delay = 0;
  int               wait_cnt = 0;
  logic [31:0]      mem [256];
  logic             ld_en = 1'b0;
  logic [7:0]       ld_addr = '0;
  logic [31:0]      ld_data = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(8)) mbus ();

  mem_access_ctrl #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_i      (phase),
    .pc_i         (pc),
    .ma_i         (ma),
    .op1_i        (op1),
    .op2_i        (op2),
    .op3_i        (op3),
    .store_data_i (store_data),
    .bus          (mbus),
    .ir_o         (ir),
    .mdr_o        (mdr),
    .stall_o      (stall),
    .err_o        (err)
  );

  // Responder: ack after ack_delay request cycles, memory write on store ack
  assign mbus.mem_rdata = mem[mbus.mem_addr];
  assign mbus.mem_ack   = man_ack | (resp_en && mbus.mem_req && (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (!mbus.mem_req || mbus.mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mbus.mem_ack && mbus.mem_req && mbus.mem_we) mem[mbus.mem_addr] <= mbus.mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic go_idle();
    phase = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick();
    n_total++;
    if ({mbus.mem_req, mbus.mem_we, stall, err} !== 4'b0000)
      $display("FAIL reset_ctrl got=%b want=0000", {mbus.mem_req, mbus.mem_we, stall, err});
    else n_pass++;
    n_total++;
    if ({ir, mdr, mbus.mem_wdata, mbus.mem_addr} !== '0)
      $display("FAIL reset_data got=%h want=0", {ir, mdr, mbus.mem_wdata, mbus.mem_addr});
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int reqs;
    poke(8'h05, 32'hDEADBEEF);
    resp_en = 1'b1;
    ack_delay = 0;
    pc = 32'h05;
    phase = '0;
    phase[PH_F] = 1'b1;
    tick();
    n_total++;
    if ({mbus.mem_req, mbus.mem_we, mbus.mem_addr, stall} !== {1'b1, 1'b0, 8'h05, 1'b1})
      $display("FAIL fetch_req got=%b%b%h%b want=1005 1", mbus.mem_req, mbus.mem_we, mbus.mem_addr, stall);
    else n_pass++;
    reqs = 1;
    tick();
    n_total++;
    if ({ir, stall} !== {32'hDEADBEEF, 1'b0})
      $display("FAIL fetch_ir got=%h/%b want=deadbeef/0", ir, stall);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (mbus.mem_req) reqs++;
      tick();
    end
    n_total++;
    if (reqs !== 1) $display("FAIL fetch_single_req got=%0d want=1", reqs);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_load();
    int hi;
    logic addr_ok;
    poke(8'h10, 32'h12345678);
    ack_delay = 3;
    ma = 32'h10;
    op1 = 8'h03; op2 = 2'b10; op3 = 3'b010;
    phase = '0;
    phase[PH_M] = 1'b1;
    hi = 0;
    addr_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      ma = 32'h33;
      if (mbus.mem_req) begin
        hi++;
        if (mbus.mem_addr !== 8'h10) addr_ok = 1'b0;
      end else if (hi > 0) break;
    end
    n_total++;
    if (hi !== 4) $display("FAIL load_req_len got=%0d want=4", hi);
    else n_pass++;
    n_total++;
    if (addr_ok !== 1'b1) $display("FAIL load_addr_stable got=%b want=1", addr_ok);
    else n_pass++;
    n_total++;
    if ({mdr, ir} !== {32'h12345678, 32'hDEADBEEF})
      $display("FAIL load_mdr got=%h/%h want=12345678/deadbeef", mdr, ir);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_store();
    int reqs;
    ack_delay = 1;
    ma = 32'h20;
    store_data = 32'hA5A5A5A5;
    op1 = 8'h23; op2 = 2'b00; op3 = 3'b010;
    phase = '0;
    phase[PH_M] = 1'b1;
    tick();
    n_total++;
    if ({mbus.mem_we, mbus.mem_wdata, mbus.mem_addr} !== {1'b1, 32'hA5A5A5A5, 8'h20})
      $display("FAIL store_req got=%b/%h/%h want=1/a5a5a5a5/20", mbus.mem_we, mbus.mem_wdata, mbus.mem_addr);
    else n_pass++;
    for (int i = 0; i < 10 && stall; i++) tick();
    n_total++;
    if ({mem[8'h20], mdr, stall} !== {32'hA5A5A5A5, 32'h12345678, 1'b0})
      $display("FAIL store_mem got=%h/%h/%b want=a5a5a5a5/12345678/0", mem[8'h20], mdr, stall);
    else n_pass++;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mbus.mem_req) reqs++;
    end
    n_total++;
    if (reqs !== 0) $display("FAIL store_no_repeat got=%0d want=0", reqs);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_timeout();
    int hi;
    resp_en = 1'b0;
    pc = 32'h07;
    phase = '0;
    phase[PH_F] = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mbus.mem_req) hi++;
      else if (hi > 0) break;
    end
    n_total++;
    if (hi !== 16) $display("FAIL timeout_len got=%0d want=16", hi);
    else n_pass++;
    n_total++;
    if ({err, stall, ir} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL timeout_flags got=%b/%b/%h want=1/0/deadbeef", err, stall, ir);
    else n_pass++;
    go_idle();
    poke(8'h06, 32'hCAFEF00D);
    resp_en = 1'b1;
    ack_delay = 0;
    pc = 32'h06;
    phase[PH_F] = 1'b1;
    tick();
    tick();
    n_total++;
    if ({ir, err} !== {32'hCAFEF00D, 1'b1})
      $display("FAIL timeout_recover got=%h/%b want=cafef00d/1", ir, err);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    ma = 32'h10;
    op1 = 8'h03; op2 = 2'b00; op3 = 3'b010;
    phase = '0;
    phase[PH_M] = 1'b1;
    tick();
    tick();
    n_total++;
    if (mbus.mem_req !== 1'b1) $display("FAIL rstmid_pre got=%b want=1", mbus.mem_req);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({mbus.mem_req, stall, err, mdr} !== {3'b000, 32'h0})
      $display("FAIL rstmid_async got=%b/%b/%b/%h want=0/0/0/0", mbus.mem_req, stall, err, mdr);
    else n_pass++;
    phase = '0;
    tick();
    rst = 1'b1;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    n_total++;
    if ({mdr, mbus.mem_req} !== {32'h0, 1'b0})
      $display("FAIL rstmid_late_ack got=%h/%b want=0/0", mdr, mbus.mem_req);
    else n_pass++;
  endtask

  task automatic test_edges();
    int reqs;
    resp_en = 1'b1;
    ack_delay = 0;
    pc = 32'h05;
    ma = 32'h10;
    op1 = 8'h03; op2 = 2'b00; op3 = 3'b010;
    phase = '0;
    phase[PH_F] = 1'b1;
    phase[PH_M] = 1'b1;
    tick();
    n_total++;
    if ({mbus.mem_we, mbus.mem_addr} !== {1'b0, 8'h05})
      $display("FAIL both_fetch got=%b/%h want=0/05", mbus.mem_we, mbus.mem_addr);
    else n_pass++;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mbus.mem_req) reqs++;
    end
    n_total++;
    if ({ir, mdr, 8'(reqs)} !== {32'hDEADBEEF, 32'h0, 8'd0})
      $display("FAIL both_only_fetch got=%h/%h/%0d want=deadbeef/0/0", ir, mdr, reqs);
    else n_pass++;
    go_idle();
    op1 = 8'h13;
    phase[PH_M] = 1'b1;
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mbus.mem_req || stall) reqs++;
    end
    n_total++;
    if (reqs !== 0) $display("FAIL other_op got=%0d want=0", reqs);
    else n_pass++;
    go_idle();
    poke(8'hFF, 32'h0BADF00D);
    pc = 32'h1FF;
    phase[PH_F] = 1'b1;
    tick();
    n_total++;
    if (mbus.mem_addr !== 8'hFF) $display("FAIL addr_trunc got=%h want=ff", mbus.mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if (ir !== 32'h0BADF00D) $display("FAIL addr_trunc_ir got=%h want=0badf00d", ir);
    else n_pass++;
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_edges();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
